// File: rtl/alu_cu_sequencer.sv
// Control-unit sequencer: accepts one instruction at a time, drives an external ALU,
// and retires results into an 8 x 32 register file with Z/N/C status flags.
module alu_cu_sequencer (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        instr_valid,
  output logic        instr_ready,
  input  logic [31:0] instr,
  output logic [5:0]  alu_opCode,
  output logic [31:0] alu_a,
  output logic [31:0] alu_b,
  output logic        alu_c,
  input  logic [31:0] alu_ans1,
  input  logic [31:0] alu_ans2,
  input  logic        alu_Z,
  input  logic        alu_N,
  output logic        done,
  output logic        illegal,
  output logic        flag_z,
  output logic        flag_n,
  output logic        flag_c,
  input  logic [2:0]  rd_addr,
  output logic [31:0] rd_data
);

  localparam logic [5:0] OP_LDI = 6'b000001;
  localparam logic [5:0] OP_LUI = 6'b000010;
  localparam logic [5:0] OP_ADD = 6'b100000;
  localparam logic [5:0] OP_SUB = 6'b100001;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_DECODE = 2'd1,
    ST_EXEC   = 2'd2,
    ST_WB     = 2'd3
  } state_t;

  function automatic logic is_alu_op(input logic [5:0] op);
    case (op)
      6'b100000, 6'b100001,
      6'b110000, 6'b110001, 6'b110010, 6'b110011,
      6'b111000, 6'b111001, 6'b111010: is_alu_op = 1'b1;
      default:                         is_alu_op = 1'b0;
    endcase
  endfunction

  function automatic logic is_load_op(input logic [5:0] op);
    case (op)
      OP_LDI, OP_LUI: is_load_op = 1'b1;
      default:        is_load_op = 1'b0;
    endcase
  endfunction

  state_t      state_q, state_d;
  logic [5:0]  op_q, op_d;
  logic [2:0]  rd_q, rd_d;
  logic [2:0]  rs1_q, rs1_d;
  logic [2:0]  rs2_q, rs2_d;
  logic [15:0] imm_q, imm_d;
  logic [31:0] res_q, res_d;
  logic        rz_q, rz_d;
  logic        rn_q, rn_d;
  logic        rc_q, rc_d;
  logic [31:0] rf_q [8];
  logic [31:0] rf_d [8];
  logic        flag_z_q, flag_z_d;
  logic        flag_n_q, flag_n_d;
  logic        flag_c_q, flag_c_d;
  logic        done_q, done_d;
  logic        illegal_q, illegal_d;
  logic [5:0]  alu_op_q, alu_op_d;
  logic [31:0] alu_a_q, alu_a_d;
  logic [31:0] alu_b_q, alu_b_d;
  logic        alu_c_q, alu_c_d;
  logic [31:0] wb_val_s;
  logic        unused_bits_s;

  // Next-state, datapath and output computation for the sequencer
  always_comb begin
    state_d   = state_q;
    op_d      = op_q;
    rd_d      = rd_q;
    rs1_d     = rs1_q;
    rs2_d     = rs2_q;
    imm_d     = imm_q;
    res_d     = res_q;
    rz_d      = rz_q;
    rn_d      = rn_q;
    rc_d      = rc_q;
    rf_d      = rf_q;
    flag_z_d  = flag_z_q;
    flag_n_d  = flag_n_q;
    flag_c_d  = flag_c_q;
    done_d    = 1'b0;
    illegal_d = 1'b0;
    alu_op_d  = 6'd0;
    alu_a_d   = 32'd0;
    alu_b_d   = 32'd0;
    alu_c_d   = 1'b0;
    wb_val_s  = 32'd0;

    case (state_q)
      ST_IDLE: begin
        if (instr_valid) begin
          op_d    = instr[31:26];
          rd_d    = instr[25:23];
          rs1_d   = instr[22:20];
          rs2_d   = instr[19:17];
          imm_d   = instr[15:0];
          state_d = ST_DECODE;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_DECODE: begin
        // ALU operands are registered here so they appear exactly for the EXEC cycle
        if (is_alu_op(op_q)) begin
          alu_op_d = op_q;
          alu_a_d  = rf_q[rs1_q];
          alu_b_d  = rf_q[rs2_q];
          alu_c_d  = flag_c_q;
          state_d  = ST_EXEC;
        end else if (is_load_op(op_q)) begin
          state_d = ST_WB;
        end else begin
          illegal_d = 1'b1;
          state_d   = ST_IDLE;
        end
      end
      ST_EXEC: begin
        res_d   = alu_ans1;
        rz_d    = alu_Z;
        rn_d    = alu_N;
        rc_d    = alu_ans2[0];
        state_d = ST_WB;
      end
      ST_WB: begin
        if (is_load_op(op_q)) begin
          if (op_q == OP_LUI) begin
            wb_val_s = {imm_q, 16'h0000};
          end else begin
            wb_val_s = {16'h0000, imm_q};
          end
          flag_z_d = (wb_val_s == 32'd0);
          flag_n_d = wb_val_s[31];
        end else begin
          wb_val_s = res_q;
          flag_z_d = rz_q;
          flag_n_d = rn_q;
          if ((op_q == OP_ADD) || (op_q == OP_SUB)) begin
            flag_c_d = rc_q;
          end else begin
            flag_c_d = flag_c_q;
          end
        end
        rf_d[rd_q] = wb_val_s;
        done_d     = 1'b1;
        state_d    = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase

    rf_d[0] = 32'd0;
  end

  // State and datapath registers with synchronous active-low reset
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q   <= ST_IDLE;
      op_q      <= 6'd0;
      rd_q      <= 3'd0;
      rs1_q     <= 3'd0;
      rs2_q     <= 3'd0;
      imm_q     <= 16'd0;
      res_q     <= 32'd0;
      rz_q      <= 1'b0;
      rn_q      <= 1'b0;
      rc_q      <= 1'b0;
      for (int i = 0; i < 8; i++) begin
        rf_q[i] <= 32'd0;
      end
      flag_z_q  <= 1'b0;
      flag_n_q  <= 1'b0;
      flag_c_q  <= 1'b0;
      done_q    <= 1'b0;
      illegal_q <= 1'b0;
      alu_op_q  <= 6'd0;
      alu_a_q   <= 32'd0;
      alu_b_q   <= 32'd0;
      alu_c_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      op_q      <= op_d;
      rd_q      <= rd_d;
      rs1_q     <= rs1_d;
      rs2_q     <= rs2_d;
      imm_q     <= imm_d;
      res_q     <= res_d;
      rz_q      <= rz_d;
      rn_q      <= rn_d;
      rc_q      <= rc_d;
      rf_q      <= rf_d;
      flag_z_q  <= flag_z_d;
      flag_n_q  <= flag_n_d;
      flag_c_q  <= flag_c_d;
      done_q    <= done_d;
      illegal_q <= illegal_d;
      alu_op_q  <= alu_op_d;
      alu_a_q   <= alu_a_d;
      alu_b_q   <= alu_b_d;
      alu_c_q   <= alu_c_d;
    end
  end

  // Debug read sees pre-write contents during WB since the file updates on the edge
  assign rd_data     = rf_q[rd_addr];
  assign instr_ready = (state_q == ST_IDLE);
  assign alu_opCode  = alu_op_q;
  assign alu_a       = alu_a_q;
  assign alu_b       = alu_b_q;
  assign alu_c       = alu_c_q;
  assign done        = done_q;
  assign illegal     = illegal_q;
  assign flag_z      = flag_z_q;
  assign flag_n      = flag_n_q;
  assign flag_c      = flag_c_q;

  assign unused_bits_s = ^{instr[16], alu_ans2[31:1]};

endmodule

// File: tb/tb_alu_cu_sequencer.sv
// Randomized scoreboard bench for alu_cu_sequencer with a behavioural ALU and
// architectural reference model (register file + flags + latency per instruction class).
module tb_alu_cu_sequencer;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        instr_valid;
  logic        instr_ready;
  logic [31:0] instr;
  logic [5:0]  alu_opCode;
  logic [31:0] alu_a, alu_b;
  logic        alu_c;
  logic [31:0] alu_ans1, alu_ans2;
  logic        alu_Z, alu_N;
  logic        done, illegal;
  logic        flag_z, flag_n, flag_c;
  logic [2:0]  rd_addr;
  logic [31:0] rd_data;

  logic [2:0]  stim_addr;
  logic [2:0]  mon_addr;
  logic        mon_en;
  logic [31:0] cyc = 32'd0;
  int          hs_cnt = 0;
  int          n_chk = 0;
  int          n_fail = 0;

  alu_cu_sequencer dut (
    .clk(clk), .rst_n(rst_n), .instr_valid(instr_valid), .instr_ready(instr_ready),
    .instr(instr), .alu_opCode(alu_opCode), .alu_a(alu_a), .alu_b(alu_b), .alu_c(alu_c),
    .alu_ans1(alu_ans1), .alu_ans2(alu_ans2), .alu_Z(alu_Z), .alu_N(alu_N),
    .done(done), .illegal(illegal), .flag_z(flag_z), .flag_n(flag_n), .flag_c(flag_c),
    .rd_addr(rd_addr), .rd_data(rd_data)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 32'd1;
  always @(posedge clk) if (rst_n && instr_valid && instr_ready) hs_cnt <= hs_cnt + 1;
  assign rd_addr = mon_en ? mon_addr : stim_addr;

  typedef struct packed {
    logic [31:0] ans1;
    logic [31:0] ans2;
    logic        z;
    logic        n;
  } alu_res_t;

  typedef struct {
    int          kind;   // 0 = done, 1 = illegal
    int          hs;
    int          lat;
    logic [2:0]  rd;
    logic [31:0] oldv;
    logic [31:0] newv;
    logic        fz, fn, fc;
    int          exec;
    logic [5:0]  op;
    logic [31:0] a, b;
    logic        c;
  } exp_t;

  exp_t sb[$];

  logic [31:0] m_rf [8];
  logic        m_z, m_n, m_c;
  logic [5:0]  legal_ops [11] = '{6'b000001, 6'b000010, 6'b100000, 6'b100001, 6'b110000,
                                  6'b110001, 6'b110010, 6'b110011, 6'b111000, 6'b111001,
                                  6'b111010};

  function automatic alu_res_t alu_model(input logic [5:0] op, input logic [31:0] a,
                                         input logic [31:0] b, input logic c);
    alu_res_t    r;
    logic [32:0] s;
    r.ans2 = 32'hFFFF_FFFF;
    case (op)
      6'b100000: begin s = {1'b0, a} + {1'b0, b} + {32'd0, c}; r.ans1 = s[31:0]; r.ans2 = {31'd0, s[32]}; end
      6'b100001: begin s = {1'b0, a} - {1'b0, b} - {32'd0, c}; r.ans1 = s[31:0]; r.ans2 = {31'd0, s[32]}; end
      6'b110000: r.ans1 = (a == b) ? 32'd1 : 32'd0;
      6'b110001: r.ans1 = (a != b) ? 32'd1 : 32'd0;
      6'b110010: r.ans1 = ($signed(a) <= $signed(b)) ? 32'd1 : 32'd0;
      6'b110011: r.ans1 = ($signed(a) > $signed(b)) ? 32'd1 : 32'd0;
      6'b111000: r.ans1 = a << b[4:0];
      6'b111001: r.ans1 = a >> b[4:0];
      6'b111010: r.ans1 = $signed(a) >>> b[4:0];
      default:   r.ans1 = 32'h0BAD_0BAD;
    endcase
    r.z = (r.ans1 == 32'd0);
    r.n = r.ans1[31];
    return r;
  endfunction

  // External ALU: real results only while an opcode is presented, junk otherwise
  always_comb begin
    alu_res_t r;
    if (alu_opCode != 6'd0) begin
      r = alu_model(alu_opCode, alu_a, alu_b, alu_c);
    end else begin
      r.ans1 = 32'hA5A5_A5A5 ^ cyc;
      r.ans2 = 32'hFFFF_FFFF;
      r.z    = 1'b1;
      r.n    = 1'b1;
    end
    alu_ans1 = r.ans1;
    alu_ans2 = r.ans2;
    alu_Z    = r.z;
    alu_N    = r.n;
  end

  function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: actual=0x%08h required=0x%08h (cycle %0d)", name, act, exp, cyc);
    end
  endfunction

  function automatic logic op_legal(input logic [5:0] op);
    for (int i = 0; i < 11; i++) if (legal_ops[i] == op) return 1'b1;
    return 1'b0;
  endfunction

  function automatic void model_reset();
    for (int i = 0; i < 8; i++) m_rf[i] = 32'd0;
    m_z = 1'b0; m_n = 1'b0; m_c = 1'b0;
  endfunction

  task automatic issue(input logic [5:0] op, input logic [2:0] rd, input logic [2:0] rs1,
                       input logic [2:0] rs2, input logic [15:0] imm);
    exp_t        e;
    alu_res_t    r;
    logic [31:0] v;
    logic        b16;
    int          n;
    @(negedge clk);
    b16 = 1'($urandom_range(0, 1));
    instr_valid = 1'b1;
    instr = {op, rd, rs1, rs2, b16, imm};
    n = 0;
    while (!instr_ready && n < 40) begin
      @(negedge clk);
      n++;
    end
    chk("ready_bound", {31'd0, (n < 40)}, 32'd1);
    e.hs = int'(cyc) + 1;
    e.rd = rd;
    e.oldv = m_rf[rd];
    e.exec = 0; e.op = 6'd0; e.a = 32'd0; e.b = 32'd0; e.c = 1'b0;
    if (!op_legal(op)) begin
      e.kind = 1; e.lat = 1; e.newv = m_rf[rd];
    end else if (op == 6'b000001 || op == 6'b000010) begin
      v = (op == 6'b000010) ? {imm, 16'h0000} : {16'h0000, imm};
      e.kind = 0; e.lat = 2;
      m_z = (v == 32'd0); m_n = v[31];
      if (rd != 3'd0) m_rf[rd] = v;
      e.newv = m_rf[rd];
    end else begin
      e.kind = 0; e.lat = 3; e.exec = 1;
      e.op = op; e.a = m_rf[rs1]; e.b = m_rf[rs2]; e.c = m_c;
      r = alu_model(op, m_rf[rs1], m_rf[rs2], m_c);
      m_z = r.z; m_n = r.n;
      if (op == 6'b100000 || op == 6'b100001) m_c = r.ans2[0];
      if (rd != 3'd0) m_rf[rd] = r.ans1;
      e.newv = m_rf[rd];
    end
    e.fz = m_z; e.fn = m_n; e.fc = m_c;
    sb.push_back(e);
    @(posedge clk);
  endtask

  task automatic idle(input int k);
    @(negedge clk);
    instr_valid = 1'b0;
    instr = $urandom();
    repeat (k) @(negedge clk);
  endtask

  task automatic wait_drain();
    int n;
    @(negedge clk);
    instr_valid = 1'b0;
    n = 0;
    while (sb.size() != 0 && n < 30) begin
      @(negedge clk);
      n++;
    end
    chk("drain", sb.size(), 32'd0);
  endtask

  task automatic read_reg(input logic [2:0] a, input logic [31:0] exp, input string name);
    stim_addr = a;
    #1;
    chk(name, rd_data, exp);
  endtask

  // Monitor: pops the scoreboard on every done/illegal pulse and checks the retirement
  initial begin
    exp_t        e;
    int          exec_cnt;
    logic [31:0] prev_rd;
    logic [5:0]  l_op;
    logic [31:0] l_a, l_b;
    logic        l_c;
    mon_en = 1'b0; mon_addr = 3'd0;
    exec_cnt = 0; prev_rd = 32'd0;
    l_op = 6'd0; l_a = 32'd0; l_b = 32'd0; l_c = 1'b0;
    forever begin
      @(posedge clk);
      #2;
      if (sb.size() != 0) begin
        mon_en = 1'b1;
        mon_addr = sb[0].rd;
      end else begin
        mon_en = 1'b0;
      end
      #1;
      if (!rst_n) begin
        exec_cnt = 0;
      end else begin
        if (alu_opCode == 6'd0) begin
          chk("alu_idle_zero", alu_a | alu_b | {31'd0, alu_c}, 32'd0);
        end else begin
          exec_cnt++;
          l_op = alu_opCode; l_a = alu_a; l_b = alu_b; l_c = alu_c;
        end
        if (done || illegal) begin
          if (sb.size() == 0) begin
            chk("unexpected_pulse", {30'd0, done, illegal}, 32'd0);
          end else begin
            e = sb.pop_front();
            chk("pulse_kind", {30'd0, done, illegal}, (e.kind == 1) ? 32'd1 : 32'd2);
            chk("latency", cyc - 32'(e.hs), 32'(e.lat));
            chk("rd_old_during_wb", prev_rd, e.oldv);
            chk("rd_new", rd_data, e.newv);
            chk("flags", {29'd0, flag_z, flag_n, flag_c}, {29'd0, e.fz, e.fn, e.fc});
            chk("exec_cycles", 32'(exec_cnt), 32'(e.exec));
            if (e.exec == 1) begin
              chk("alu_opcode", {26'd0, l_op}, {26'd0, e.op});
              chk("alu_a", l_a, e.a);
              chk("alu_b", l_b, e.b);
              chk("alu_c", {31'd0, l_c}, {31'd0, e.c});
            end
            if (sb.size() == 0) mon_en = 1'b0;
          end
          exec_cnt = 0;
        end
        prev_rd = rd_data;
      end
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: actual=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int hs_before;
    logic [5:0] op;
    model_reset();
    rst_n = 1'b0; instr_valid = 1'b0; instr = 32'd0; stim_addr = 3'd0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    chk("rst_ready", {31'd0, instr_ready}, 32'd1);
    chk("rst_pulses", {30'd0, done, illegal}, 32'd0);
    chk("rst_alu", {26'd0, alu_opCode} | alu_a | alu_b | {31'd0, alu_c}, 32'd0);
    chk("rst_flags", {29'd0, flag_z, flag_n, flag_c}, 32'd0);
    for (int i = 0; i < 8; i++) read_reg(3'(i), 32'd0, "rst_reg");

    issue(6'b000010, 3'd1, 3'd0, 3'd0, 16'h0001);         // LUI r1
    issue(6'b000001, 3'd2, 3'd0, 3'd0, 16'h0001);         // LDI r2
    issue(6'b110001, 3'd3, 3'd1, 3'd2, 16'h0000);         // NE r3
    issue(6'b000010, 3'd6, 3'd0, 3'd0, 16'h8000);         // LUI r6
    issue(6'b100000, 3'd4, 3'd6, 3'd6, 16'h0000);         // ADD with carry out
    issue(6'b100000, 3'd5, 3'd1, 3'd2, 16'h0000);         // ADD consumes carry-in
    issue(6'b000010, 3'd6, 3'd0, 3'd0, 16'h8000);
    issue(6'b100000, 3'd4, 3'd6, 3'd6, 16'h0000);
    issue(6'b110001, 3'd3, 3'd1, 3'd2, 16'h0000);         // NE keeps C
    wait_drain();
    chk("flag_c_held", {31'd0, flag_c}, 32'd1);
    read_reg(3'd1, 32'h0001_0000, "r1_lui");
    read_reg(3'd2, 32'h0000_0001, "r2_ldi");

    issue(6'b011111, 3'd1, 3'd2, 3'd3, 16'h1234);         // illegal
    issue(6'b000001, 3'd0, 3'd0, 3'd0, 16'hFFFF);         // LDI r0
    wait_drain();
    read_reg(3'd0, 32'd0, "r0_zero");
    read_reg(3'd1, 32'h0001_0000, "r1_after_illegal");

    hs_before = hs_cnt;
    issue(6'b100001, 3'd7, 3'd1, 3'd2, 16'h0000);
    issue(6'b000001, 3'd3, 3'd0, 3'd0, 16'h00A5);
    wait_drain();
    chk("held_valid_handshakes", 32'(hs_cnt - hs_before), 32'd2);

    for (int k = 0; k < 150; k++) begin
      if ($urandom_range(0, 3) == 0) idle($urandom_range(0, 3));
      if ($urandom_range(0, 11) == 0) op = 6'($urandom());
      else op = legal_ops[$urandom_range(0, 10)];
      issue(op, 3'($urandom()), 3'($urandom()), 3'($urandom()), 16'($urandom()));
    end
    wait_drain();

    issue(6'b100000, 3'd5, 3'd1, 3'd1, 16'h0000);         // ADD r5, reset in EXEC
    @(negedge clk);
    @(negedge clk);
    chk("in_exec_before_reset", {26'd0, alu_opCode}, 32'h20);
    rst_n = 1'b0;
    instr_valid = 1'b0;
    sb.delete();
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;
    chk("abort_ready", {31'd0, instr_ready}, 32'd1);
    chk("abort_flags", {29'd0, flag_z, flag_n, flag_c}, 32'd0);
    chk("abort_pulses", {30'd0, done, illegal}, 32'd0);
    read_reg(3'd5, 32'd0, "abort_r5");
    repeat (6) @(negedge clk);
    read_reg(3'd1, 32'd0, "abort_r1");

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/alu_cu_sequencer.md
ALU_CU_SEQUENCER -- requirements
Module: alu_cu_sequencer

Interface
REQ-001 The block SHALL have the following ports:
- clk  input  1  single clock; all state changes on rising edge
- rst_n  input  1  reset, synchronous, active-low
- instr_valid  input  1  instruction offered
- instr_ready  output  1  block can accept an instruction
- instr  input  32  [31:26] op, [25:23] rd, [22:20] rs1, [19:17] rs2, [15:0] imm16
- alu_opCode  output  6  opcode driven to the external ALU
- alu_a  output  32  operand A to the ALU
- alu_b  output  32  operand B to the ALU
- alu_c  output  1  carry-in to the ALU (C flag)
- alu_ans1  input  32  ALU primary result
- alu_ans2  input  32  ALU secondary result; bit 0 is carry/borrow out
- alu_Z  input  1  ALU zero indication
- alu_N  input  1  ALU negative indication
- done  output  1  one-cycle pulse when an instruction retires
- illegal  output  1  one-cycle pulse when an opcode is rejected
- flag_z, flag_n, flag_c  output  1 each  registered status flags
- rd_addr  input  3  debug register read address
- rd_data  output  32  debug register read data, combinational

Function
REQ-002 Register file: 8 x 32 bits; r0 SHALL read 0 always; writes to r0 SHALL be discarded, with flags still updated.
REQ-003 Legal opcodes: 000001 LDI (rd = {16'h0, imm16}); 000010 LUI (rd = {imm16, 16'h0}); 100000 ADD; 100001 SUB; 110000 EQ; 110001 NE; 110010 LE; 110011 GT; 111000 LLS; 111001 LRS; 111010 ARS. Any other opcode is illegal.
REQ-004 FSM states: IDLE, DECODE, EXEC, WB.
REQ-005 instr_ready SHALL be 1 only in IDLE.
REQ-006 A handshake occurs when instr_valid and instr_ready are both 1 on a rising edge. On a handshake, instr SHALL be latched and the FSM SHALL go to DECODE.
REQ-007 DECODE transitions:
- illegal opcode -> pulse illegal for 1 cycle, go to IDLE; no register or flag change
- LDI/LUI -> WB
- ALU opcode -> EXEC
REQ-008 In EXEC, the block SHALL present these values for exactly 1 cycle: alu_opCode = op, alu_a = reg[rs1], alu_b = reg[rs2], alu_c = flag_c. It SHALL sample alu_ans1, alu_ans2, alu_Z and alu_N at the end of that cycle, then go to WB.
REQ-009 In WB, the block SHALL:
- write rd with the result (ALU ops: ans1)
- set flag_z = alu_Z and flag_n = alu_N (LDI/LUI: computed from the loaded value)
- set flag_c = alu_ans2[0] for ADD/SUB only; other ops hold flag_c
- pulse done, go to IDLE
REQ-010 Latency from a handshake at edge T: ALU ops SHALL raise done in the cycle after edge T+3; LDI/LUI in the cycle after edge T+2; illegal SHALL pulse in the cycle after edge T+1.
REQ-011 Outside EXEC, alu_opCode, alu_a, alu_b and alu_c SHALL be 0.
REQ-012 Operand reads SHALL use register contents as of the EXEC cycle. No forwarding is needed because instructions never overlap.
REQ-013 rd_data SHALL return reg[rd_addr]. A read in the same cycle as a WB write to that address SHALL return the old value.
REQ-014 instr_valid asserted while the FSM is not in IDLE SHALL be ignored and SHALL have no effect.
REQ-015 All arithmetic is 32-bit modulo; results come only from the ALU, and the block SHALL perform no width extension beyond REQ-003.

Reset
REQ-016 When rst_n = 0 at a rising edge, the block SHALL:
- go to IDLE
- clear all registers and flags to 0
- drive done = 0, illegal = 0 and all alu_* outputs = 0
- drive instr_ready = 1 from the first cycle after reset deasserts
REQ-017 Reset in any state (mid-instruction) SHALL abort the instruction with no register write and no done pulse.

Verification
REQ-018 LUI r1, 0x0001 then LDI r2, 0x0001 -> r1 = 0x00010000 and r2 = 0x00000001; each done arrives 2 cycles after its handshake edge; flag_z = 0.
REQ-019 With a model ALU: NE (110001) r3, r1, r2 -> alu_opCode = 110001, alu_a = 0x00010000, alu_b = 0x00000001 during EXEC; r3 = model ans1; done arrives 3 cycles after the handshake edge.
REQ-020 ADD r4, r1, r1 with model ans2 = 1 -> flag_c = 1. The next ADD SHALL drive alu_c = 1. A following NE SHALL leave flag_c = 1.
REQ-021 Opcode 6'b011111 -> illegal pulses in the cycle after the edge following the handshake; no register changes; done stays 0; instr_ready is back to 1 within 2 cycles.
REQ-022 LDI r0, 0xFFFF -> r0 reads 0; done pulses. instr_valid held high during EXEC of another instruction -> exactly one extra handshake occurs, only after return to IDLE.
REQ-023 rst_n = 0 during EXEC of ADD r5 -> r5 stays 0, no done pulse, all flags 0, instr_ready = 1 after release.
